bus_controller: RTL and testbench
=================================

BUS_CONTROLLER -- requirements
Module: bus_controller

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 2, meaning cycles RD/WR strobe held per byte (legal 1..15).
REQ-002 SHALL have ports clk input 1, sole clock, all logic on rising edge.
REQ-003 SHALL have port rst input 1, reset, synchronous and active-high.
REQ-004 SHALL have port address input 24, byte address of request; bits [23:16] ignored.
REQ-005 SHALL have port read input 1, read request level.
REQ-006 SHALL have port write input 1, write request level.
REQ-007 SHALL have port byteCount input 2, transfer length minus one (0=1 byte .. 3=4 bytes).
REQ-008 SHALL have port dataIn input 32, write data, little-endian.
REQ-009 SHALL have port dataOut output 32, read data, little-endian.
REQ-010 SHALL have port dataOutReady output 1, one-cycle pulse: read complete, dataOut valid.
REQ-011 SHALL have port dataInReady output 1, one-cycle pulse: write complete.
REQ-012 SHALL have ports busOut output 8, busOe output 1, busIn input 8: shared external byte bus.
REQ-013 SHALL have outputs addressLatch0, addressLatch1, ramChipEnable, ramRead, ramWrite, romChipEnable, romRead, each 1 bit, active-high.

Function
REQ-014 SHALL use states IDLE, LAT_LO, LAT_HI, ACCESS, RECOVER, DONE.
REQ-015 IDLE: request sampled on edge when read or write high; both high -> read wins; next state LAT_LO; address, byteCount, dataIn, direction captured.
REQ-016 Region decode on captured address[15]: 0 -> ROM, 1 -> RAM.
REQ-017 LAT_LO (1 cycle): busOe=1, busOut=current address[7:0], addressLatch0=1.
REQ-018 LAT_HI (1 cycle): busOe=1, busOut=current address[15:8], addressLatch1=1.
REQ-019 ACCESS (ACCESS_CYCLES cycles): selected CE=1; read -> busOe=0, ramRead/romRead=1, busIn sampled on final cycle into byte lane k; RAM write -> busOe=1, busOut=data byte k, ramWrite=1.
REQ-020 ROM write: no strobes asserted during ACCESS, sequencing and timing unchanged, dataInReady still pulsed.
REQ-021 RECOVER (1 cycle): all CE/RD/WR low, busOe=0; if bytes remain, byte index +1, address[15:0] +1 wrapping 0xFFFF->0x0000, next LAT_LO; else DONE.
REQ-022 DONE (1 cycle): pulse dataOutReady (read) or dataInReady (write); next IDLE; new request accepted no earlier than IDLE.
REQ-023 Read data: dataOut lanes above byteCount SHALL be zero; dataOut held stable until next read's first sample.
REQ-024 Latency without macro: ready pulse in cycle 1 + n*(ACCESS_CYCLES+3) after capture edge, n=byteCount+1.
REQ-025 At most one of addressLatch0, addressLatch1, any RD/WR strobe high in any cycle; RD and WR never simultaneous.
REQ-026 Request inputs changing mid-transfer SHALL be ignored.

Reset
REQ-027 rst high at edge: state IDLE, all strobes/latches/ready low, busOe=0, busOut=0, dataOut=0; transfer in progress aborted with no ready pulse.

Configuration
REQ-028 Macro BUS_CONTROLLER_LATCH_SKIP_EN defined: for bytes after the first, LAT_HI SHALL be skipped when address[15:8] unchanged (LAT_LO -> ACCESS); latency reduced by 1 per skipped byte.
REQ-029 Macro undefined: LAT_HI executed for every byte per REQ-024.

Verification
REQ-030 Read 1 byte, address 0x008123 (RAM), busIn=0x5A, ACCESS_CYCLES=2 -> latches 0x23 then 0x81, ramRead 2 cycles, dataOutReady 6 cycles after capture, dataOut=0x0000005A.
REQ-031 Write 4 bytes, address 0x00FFFE, dataIn=0xDDCCBBAA -> RAM bytes AA,BB,CC,DD at 0xFFFE,0xFFFF,0x0000,0x0001; 0x0000 is ROM: no strobe for CC,DD, dataInReady at cycle 21.
REQ-032 read and write both high, address 0x000010 -> read from ROM, romRead asserted, ramWrite never asserted, dataOutReady only.
REQ-033 rst asserted during ACCESS of byte 2 of 3-byte read -> next cycle all strobes low, IDLE, no dataOutReady; following 1-byte read completes normally.
REQ-034 Macro defined, read 3 bytes at 0x008010 -> addressLatch1 pulses once, dataOutReady at cycle 14.

Source files
------------

// File: rtl/bus_controller.sv
// bus_controller: sequences 1..4 byte transfers over a shared byte bus with two address latches.
// Option: define BUS_CONTROLLER_LATCH_SKIP_EN to skip the high-address latch when address[15:8] is unchanged.
module bus_controller #(
   parameter int unsigned ACCESS_CYCLES = 32'd2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [1:0]  byteCount,
   input  logic [31:0] dataIn,
   output logic [31:0] dataOut,
   output logic        dataOutReady,
   output logic        dataInReady,
   output logic [7:0]  busOut,
   output logic        busOe,
   input  logic [7:0]  busIn,
   output logic        addressLatch0,
   output logic        addressLatch1,
   output logic        ramChipEnable,
   output logic        ramRead,
   output logic        ramWrite,
   output logic        romChipEnable,
   output logic        romRead
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] LAT_LO  = 3'd1;
   localparam logic [2:0] LAT_HI  = 3'd2;
   localparam logic [2:0] ACCESS  = 3'd3;
   localparam logic [2:0] RECOVER = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   localparam logic [3:0] ACC_LAST = 4'(ACCESS_CYCLES - 32'd1);

   logic [2:0]  state_r, nextState_s;
   logic [15:0] addr_r, nextAddr_s;
   logic [1:0]  count_r, nextCount_s;
   logic [1:0]  byteIdx_r, nextIdx_s;
   logic [31:0] data_r, nextData_s;
   logic        isRead_r, nextIsRead_s;
   logic [3:0]  accCnt_r, nextAcc_s;

   logic [7:0]  busOut_s, wrByte_s;
   logic        busOe_s, lat0_s, lat1_s, ramCe_s, ramRd_s, ramWr_s, romCe_s, romRd_s;
   logic        outRdy_s, inRdy_s, sampleByte_s;
   logic        unusedAddrHi_s;

   assign unusedAddrHi_s = ^address[23:16];
   assign sampleByte_s   = (state_r == ACCESS) && (accCnt_r == ACC_LAST) && isRead_r;

   // Next-state and transfer bookkeeping.
   always_comb begin
      nextState_s  = state_r;
      nextAddr_s   = addr_r;
      nextCount_s  = count_r;
      nextIdx_s    = byteIdx_r;
      nextData_s   = data_r;
      nextIsRead_s = isRead_r;
      nextAcc_s    = accCnt_r;
      case (state_r)
         IDLE: begin
            if (read || write) begin
               nextState_s  = LAT_LO;
               nextAddr_s   = address[15:0];
               nextCount_s  = byteCount;
               nextData_s   = dataIn;
               nextIsRead_s = read;
               nextIdx_s    = 2'd0;
            end else begin
               nextState_s  = IDLE;
            end
         end
         LAT_LO: begin
            nextAcc_s = 4'd0;
`ifdef BUS_CONTROLLER_LATCH_SKIP_EN
            // Address only ever steps by one, so the high byte moved iff the low byte wrapped to zero.
            if ((byteIdx_r != 2'd0) && (addr_r[7:0] != 8'h00)) begin
               nextState_s = ACCESS;
            end else begin
               nextState_s = LAT_HI;
            end
`else
            nextState_s = LAT_HI;
`endif
         end
         LAT_HI: begin
            nextState_s = ACCESS;
            nextAcc_s   = 4'd0;
         end
         ACCESS: begin
            if (accCnt_r == ACC_LAST) begin
               nextState_s = RECOVER;
            end else begin
               nextState_s = ACCESS;
               nextAcc_s   = accCnt_r + 4'd1;
            end
         end
         RECOVER: begin
            if (byteIdx_r != count_r) begin
               nextState_s = LAT_LO;
               nextIdx_s   = byteIdx_r + 2'd1;
               nextAddr_s  = addr_r + 16'd1;
            end else begin
               nextState_s = DONE;
            end
         end
         DONE:    nextState_s = IDLE;
         default: nextState_s = IDLE;
      endcase
   end

   // Bus outputs decoded from the upcoming state so the registered outputs line up with it.
   always_comb begin
      busOut_s = 8'h00;
      busOe_s  = 1'b0;
      lat0_s   = 1'b0;
      lat1_s   = 1'b0;
      ramCe_s  = 1'b0;
      ramRd_s  = 1'b0;
      ramWr_s  = 1'b0;
      romCe_s  = 1'b0;
      romRd_s  = 1'b0;
      outRdy_s = 1'b0;
      inRdy_s  = 1'b0;
      wrByte_s = nextData_s[{nextIdx_s, 3'b000} +: 8];
      case (nextState_s)
         LAT_LO: begin
            busOe_s  = 1'b1;
            busOut_s = nextAddr_s[7:0];
            lat0_s   = 1'b1;
         end
         LAT_HI: begin
            busOe_s  = 1'b1;
            busOut_s = nextAddr_s[15:8];
            lat1_s   = 1'b1;
         end
         ACCESS: begin
            if (nextIsRead_s) begin
               ramCe_s = nextAddr_s[15];
               ramRd_s = nextAddr_s[15];
               romCe_s = ~nextAddr_s[15];
               romRd_s = ~nextAddr_s[15];
            end else if (nextAddr_s[15]) begin
               ramCe_s  = 1'b1;
               ramWr_s  = 1'b1;
               busOe_s  = 1'b1;
               busOut_s = wrByte_s;
            end else begin
               busOe_s  = 1'b0;   // ROM cannot be written: bus stays idle
            end
         end
         DONE: begin
            outRdy_s = nextIsRead_s;
            inRdy_s  = ~nextIsRead_s;
         end
         default: busOe_s = 1'b0;
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         addr_r        <= 16'h0000;
         count_r       <= 2'd0;
         byteIdx_r     <= 2'd0;
         data_r        <= 32'h0000_0000;
         isRead_r      <= 1'b0;
         accCnt_r      <= 4'd0;
         dataOut       <= 32'h0000_0000;
         dataOutReady  <= 1'b0;
         dataInReady   <= 1'b0;
         busOut        <= 8'h00;
         busOe         <= 1'b0;
         addressLatch0 <= 1'b0;
         addressLatch1 <= 1'b0;
         ramChipEnable <= 1'b0;
         ramRead       <= 1'b0;
         ramWrite      <= 1'b0;
         romChipEnable <= 1'b0;
         romRead       <= 1'b0;
      end else begin
         state_r       <= nextState_s;
         addr_r        <= nextAddr_s;
         count_r       <= nextCount_s;
         byteIdx_r     <= nextIdx_s;
         data_r        <= nextData_s;
         isRead_r      <= nextIsRead_s;
         accCnt_r      <= nextAcc_s;
         dataOutReady  <= outRdy_s;
         dataInReady   <= inRdy_s;
         busOut        <= busOut_s;
         busOe         <= busOe_s;
         addressLatch0 <= lat0_s;
         addressLatch1 <= lat1_s;
         ramChipEnable <= ramCe_s;
         ramRead       <= ramRd_s;
         ramWrite      <= ramWr_s;
         romChipEnable <= romCe_s;
         romRead       <= romRd_s;
         // First byte of a read clears the upper lanes so short reads return zeros above byteCount.
         if (sampleByte_s && (byteIdx_r == 2'd0)) begin
            dataOut <= {24'h000000, busIn};
         end else if (sampleByte_s) begin
            dataOut[{byteIdx_r, 3'b000} +: 8] <= busIn;
         end else begin
            dataOut <= dataOut;
         end
      end
   end

endmodule

// File: tb/tb_bus_controller.sv
// Self-checking bench for bus_controller: external latch/memory model plus a ready-pulse scoreboard.
module tb_bus_controller;

   localparam int unsigned AC = 32'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] address;
   logic        read, write;
   logic [1:0]  byteCount;
   logic [31:0] dataIn, dataOut;
   logic        dataOutReady, dataInReady;
   logic [7:0]  busOut, busIn;
   logic        busOe, addressLatch0, addressLatch1;
   logic        ramChipEnable, ramRead, ramWrite, romChipEnable, romRead;

   bus_controller #(.ACCESS_CYCLES(AC)) dut (
      .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
      .byteCount(byteCount), .dataIn(dataIn), .dataOut(dataOut),
      .dataOutReady(dataOutReady), .dataInReady(dataInReady),
      .busOut(busOut), .busOe(busOe), .busIn(busIn),
      .addressLatch0(addressLatch0), .addressLatch1(addressLatch1),
      .ramChipEnable(ramChipEnable), .ramRead(ramRead), .ramWrite(ramWrite),
      .romChipEnable(romChipEnable), .romRead(romRead)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        isRead;
      logic [31:0] data;
      int          lat;
   } exp_t;

   exp_t        sbQ[$];
   int          checks = 0, errors = 0;
   int          cyc = 0, capCyc = 0;
   int          lat0Cnt, lat1Cnt, ramRdCyc, romRdCyc, ramWrCyc, exclViol = 0;
   logic [7:0]  firstLo, firstHi;
   logic [7:0]  loLatch, hiLatch;
   logic [7:0]  mem [0:65535];

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] romPat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hF8;
   endfunction

   function automatic logic [31:0] expRead(input logic [15:0] a, input logic [1:0] cnt);
      logic [31:0] r;
      logic [15:0] ai;
      r = 32'h0;
      for (int i = 0; i <= int'(cnt); i++) begin
         ai = a + 16'(i);
         r[8*i +: 8] = romPat(ai);
      end
      return r;
   endfunction

   function automatic int expLat(input logic [15:0] a, input logic [1:0] cnt);
      int lat;
      logic [15:0] cur, prev;
      lat = 1;
      for (int i = 0; i <= int'(cnt); i++) begin
         lat += int'(AC) + 3;
         cur  = a + 16'(i);
         prev = cur - 16'd1;
`ifdef BUS_CONTROLLER_LATCH_SKIP_EN
         if ((i > 0) && (cur[15:8] == prev[15:8])) lat -= 1;
`endif
      end
      return lat;
   endfunction

   // External 74x373-style address latches and a byte memory on the shared bus.
   assign busIn = mem[{hiLatch, loLatch}];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         loLatch <= 8'h00;
         hiLatch <= 8'h00;
      end else begin
         if (addressLatch0) loLatch <= busOut;
         if (addressLatch1) hiLatch <= busOut;
         if (ramWrite && ramChipEnable) mem[{hiLatch, loLatch}] <= busOut;
      end
   end

   // Strobe statistics, exclusivity and the ready-pulse scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (int'(addressLatch0) + int'(addressLatch1) + int'(ramRead) + int'(romRead) + int'(ramWrite) > 1)
         exclViol++;
      if (addressLatch0 && lat0Cnt == 0) firstLo = busOut;
      if (addressLatch1 && lat1Cnt == 0) firstHi = busOut;
      lat0Cnt  += int'(addressLatch0);
      lat1Cnt  += int'(addressLatch1);
      ramRdCyc += int'(ramRead);
      romRdCyc += int'(romRead);
      ramWrCyc += int'(ramWrite);
      if (dataOutReady || dataInReady) begin
         if (sbQ.size() == 0) begin
            checkVal("unexpected_ready", {30'd0, dataOutReady, dataInReady}, 32'd0);
         end else begin
            e = sbQ.pop_front();
            checkVal("ready_out", {31'd0, dataOutReady}, {31'd0, e.isRead});
            checkVal("ready_in", {31'd0, dataInReady}, {31'd0, ~e.isRead});
            checkVal("latency", 32'(cyc - capCyc + 1), 32'(e.lat));
            if (e.isRead) checkVal("read_data", dataOut, e.data);
         end
      end
   end

   task automatic clearStats();
      lat0Cnt = 0; lat1Cnt = 0; ramRdCyc = 0; romRdCyc = 0; ramWrCyc = 0;
   endtask

   task automatic doXfer(input logic rd, input logic wr, input logic [23:0] addr,
                         input logic [1:0] cnt, input logic [31:0] din, input logic [31:0] expData);
      exp_t e;
      bit   seen;
      @(negedge clk);
      read = rd; write = wr; address = addr; byteCount = cnt; dataIn = din;
      e.isRead = rd; e.data = expData; e.lat = expLat(addr[15:0], cnt);
      sbQ.push_back(e);
      @(posedge clk); #1;
      capCyc = cyc;
      clearStats();
      read = 1'b0; write = 1'b0;
      address = 24'($urandom); dataIn = $urandom; byteCount = 2'($urandom);
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         write = (i == 1);   // stray request mid-transfer must be ignored
         if (dataOutReady || dataInReady) begin
            seen = 1'b1;
            break;
         end
      end
      write = 1'b0;
      if (!seen) checkVal("xfer_timeout", 32'd0, 32'd1);
      #1;
   endtask

   initial begin
      bit hit;
      int lo;
      for (int i = 0; i < 65536; i++) mem[i] <= romPat(16'(i));
      clearStats();
      rst = 1'b1; read = 1'b0; write = 1'b0; address = 24'h0; byteCount = 2'd0; dataIn = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkVal("reset_ctrl", {22'd0, busOe, addressLatch0, addressLatch1, ramChipEnable, ramRead,
                              ramWrite, romChipEnable, romRead, dataOutReady, dataInReady}, 32'd0);
      checkVal("reset_busout", {24'd0, busOut}, 32'd0);
      checkVal("reset_dataout", dataOut, 32'd0);
      rst = 1'b0;

      // 1-byte RAM read, high address byte ignored
      doXfer(1'b1, 1'b0, 24'h008123, 2'd0, 32'h0, 32'h0000_005A);
      checkVal("r1_lat_lo", {24'd0, firstLo}, 32'h23);
      checkVal("r1_lat_hi", {24'd0, firstHi}, 32'h81);
      checkVal("r1_ramrd_cycles", 32'(ramRdCyc), 32'(AC));
      checkVal("r1_romrd_cycles", 32'(romRdCyc), 32'd0);

      // 4-byte write wrapping from RAM into ROM
      doXfer(1'b0, 1'b1, 24'h00FFFE, 2'd3, 32'hDDCC_BBAA, 32'h0);
      checkVal("w4_mem_fffe", {24'd0, mem[16'hFFFE]}, 32'hAA);
      checkVal("w4_mem_ffff", {24'd0, mem[16'hFFFF]}, 32'hBB);
      checkVal("w4_mem_0000", {24'd0, mem[16'h0000]}, {24'd0, romPat(16'h0000)});
      checkVal("w4_mem_0001", {24'd0, mem[16'h0001]}, {24'd0, romPat(16'h0001)});
      checkVal("w4_ramwr_cycles", 32'(ramWrCyc), 32'(2 * AC));
      checkVal("w4_lat0_count", 32'(lat0Cnt), 32'd4);
      checkVal("dataout_hold", dataOut, 32'h0000_005A);

      // read and write together: read wins, ROM region
      doXfer(1'b1, 1'b1, 24'hC30010, 2'd0, 32'h1111_1111, expRead(16'h0010, 2'd0));
      checkVal("rw_romrd_cycles", 32'(romRdCyc), 32'(AC));
      checkVal("rw_ramwr_cycles", 32'(ramWrCyc), 32'd0);

      doXfer(1'b1, 1'b0, 24'h0080FE, 2'd3, 32'h0, expRead(16'h80FE, 2'd3));
      doXfer(1'b1, 1'b0, 24'h001234, 2'd2, 32'h0, expRead(16'h1234, 2'd2));
      doXfer(1'b0, 1'b1, 24'h009000, 2'd1, 32'h1234_BEEF, 32'h0);
      doXfer(1'b1, 1'b0, 24'h009000, 2'd1, 32'h0, 32'h0000_BEEF);

      // 3-byte read in one high-address page
      doXfer(1'b1, 1'b0, 24'h008010, 2'd2, 32'h0, expRead(16'h8010, 2'd2));
`ifdef BUS_CONTROLLER_LATCH_SKIP_EN
      checkVal("page_lat1_count", 32'(lat1Cnt), 32'd1);
`else
      checkVal("page_lat1_count", 32'(lat1Cnt), 32'd3);
`endif

      // reset during ACCESS of byte 2 of a 3-byte read: no ready pulse may follow
      @(negedge clk);
      read = 1'b1; address = 24'h008200; byteCount = 2'd2;
      @(posedge clk); #1;
      read = 1'b0;
      hit = 1'b0; lo = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (addressLatch0) lo++;
         if (lo == 2 && ramRead) begin
            hit = 1'b1;
            break;
         end
      end
      checkVal("abort_reached_byte2", {31'd0, hit}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      checkVal("abort_ctrl", {22'd0, busOe, addressLatch0, addressLatch1, ramChipEnable, ramRead,
                              ramWrite, romChipEnable, romRead, dataOutReady, dataInReady}, 32'd0);
      checkVal("abort_dataout", dataOut, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      doXfer(1'b1, 1'b0, 24'h008200, 2'd0, 32'h0, expRead(16'h8200, 2'd0));

      repeat (3) @(negedge clk);
      checkVal("strobe_exclusive", 32'(exclViol), 32'd0);
      checkVal("scoreboard_drained", 32'(sbQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
